// File: rtl/dcache_array_swp.sv
// dcache_array_swp: dual-read, granule-masked cache state array
// with a self-timed clear sweep used after reset and on request.
module dcache_array_swp #(
  parameter int s_index = 3,
  parameter int width   = 24,
  parameter int gran    = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  output logic                    busy,
  input  logic                    read0,
  input  logic [s_index-1:0]      rindex0,
  output logic [width-1:0]        dataout0,
  input  logic                    read1,
  input  logic [s_index-1:0]      rindex1,
  output logic [width-1:0]        dataout1,
  input  logic                    load,
  input  logic [s_index-1:0]      windex,
  input  logic [width/gran-1:0]   wmask,
  input  logic [width-1:0]        datain
);

  localparam int num_sets = 2**s_index;
  localparam int nmask    = width / gran;
  localparam logic [s_index-1:0] LAST = '1;

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t                r_state;
  state_t                w_next;
  logic [s_index-1:0]    r_ptr;
  logic [width-1:0]      r_data [num_sets];
  logic [width-1:0]      w_fwd0;
  logic [width-1:0]      w_fwd1;
  logic                  w_idle;

  assign w_idle = (r_state == IDLE);

  // State and sweep pointer; reset restarts the sweep from set 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= SWEEP;
      r_ptr   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == SWEEP)
        r_ptr <= (r_ptr == LAST) ? '0 : r_ptr + 1'b1;
    end
  end

  // Next state: clear starts a sweep, sweep ends after the last set
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:  if (clear) w_next = SWEEP;
      SWEEP: if (r_ptr == LAST) w_next = IDLE;
      default: w_next = SWEEP;
    endcase
  end

  // Busy is a pure decode of the registered state
  always_comb begin
    busy = (r_state == SWEEP);
  end

  // Storage: sweep zeroes one set per cycle, otherwise masked write
  always_ff @(posedge clk) begin
    if (r_state == SWEEP) begin
      r_data[r_ptr] <= '0;
    end else if (load) begin
      for (int g = 0; g < nmask; g++)
        if (wmask[g])
          r_data[windex][g*gran +: gran] <= datain[g*gran +: gran];
    end
  end

  // Per-granule forwarding of a same-cycle write onto both read ports
  always_comb begin
    w_fwd0 = r_data[rindex0];
    w_fwd1 = r_data[rindex1];
    for (int g = 0; g < nmask; g++) begin
      if (load && wmask[g] && (windex == rindex0))
        w_fwd0[g*gran +: gran] = datain[g*gran +: gran];
      if (load && wmask[g] && (windex == rindex1))
        w_fwd1[g*gran +: gran] = datain[g*gran +: gran];
    end
  end

  // Registered read ports; hold when not reading or while sweeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dataout0 <= '0;
      dataout1 <= '0;
    end else begin
      if (w_idle && read0) dataout0 <= w_fwd0;
      if (w_idle && read1) dataout1 <= w_fwd1;
    end
  end

endmodule

// File: tb/tb_dcache_array_swp.sv
// tb_dcache_array_swp: directed vector table plus hand-written
// sequences for reset sweep, clear sweep and mid-sweep reset.
module tb_dcache_array_swp;

  logic        clk;
  logic        rst;
  logic        clear;
  logic        busy;
  logic        read0;
  logic [2:0]  rindex0;
  logic [23:0] dataout0;
  logic        read1;
  logic [2:0]  rindex1;
  logic [23:0] dataout1;
  logic        load;
  logic [2:0]  windex;
  logic [2:0]  wmask;
  logic [23:0] datain;

  int n_tests = 0;
  int n_fail  = 0;

  dcache_array_swp #(.s_index(3), .width(24), .gran(8)) dut (
    .clk(clk), .rst(rst), .clear(clear), .busy(busy),
    .read0(read0), .rindex0(rindex0), .dataout0(dataout0),
    .read1(read1), .rindex1(rindex1), .dataout1(dataout1),
    .load(load), .windex(windex), .wmask(wmask), .datain(datain)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ld;
    logic [2:0]  wi;
    logic [2:0]  wm;
    logic [23:0] din;
    logic        rd0;
    logic [2:0]  ri0;
    logic        rd1;
    logic [2:0]  ri1;
    logic [23:0] e0;
    logic [23:0] e1;
  } vec_t;

  vec_t tbl [14];

  function automatic vec_t mk(
    input logic ld, input logic [2:0] wi, input logic [2:0] wm,
    input logic [23:0] din,
    input logic rd0, input logic [2:0] ri0,
    input logic rd1, input logic [2:0] ri1,
    input logic [23:0] e0, input logic [23:0] e1);
    vec_t v;
    v.ld = ld; v.wi = wi; v.wm = wm; v.din = din;
    v.rd0 = rd0; v.ri0 = ri0; v.rd1 = rd1; v.ri1 = ri1;
    v.e0 = e0; v.e1 = e1;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [23:0] act,
                     input logic [23:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %06h expected %06h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    clear = 0; load = 0; windex = 0; wmask = 0; datain = 0;
    read0 = 0; rindex0 = 0; read1 = 0; rindex1 = 0;
  endtask

  // busy must be high before exactly 8 edges, then low
  task automatic sweep_len(input string nm);
    for (int i = 0; i < 8; i++) begin
      chk({nm, "_busy_hi"}, {23'd0, busy}, 24'd1);
      cyc();
    end
    chk({nm, "_busy_lo"}, {23'd0, busy}, 24'd0);
  endtask

  task automatic read_all_zero(input string nm);
    for (int s = 0; s < 8; s++) begin
      idle_in();
      read0 = 1; rindex0 = 3'(s);
      read1 = 1; rindex1 = 3'(7 - s);
      cyc();
      chk({nm, "_p0"}, dataout0, 24'h0);
      chk({nm, "_p1"}, dataout1, 24'h0);
    end
    idle_in();
  endtask

  initial begin
    tbl[0]  = mk(1, 5, 3'b111, 24'hAABBCC, 0, 0, 0, 0, 24'h000000, 24'h000000);
    tbl[1]  = mk(1, 5, 3'b010, 24'h112233, 1, 5, 0, 0, 24'hAA22CC, 24'h000000);
    tbl[2]  = mk(0, 0, 3'b000, 24'h000000, 1, 5, 1, 5, 24'hAA22CC, 24'hAA22CC);
    tbl[3]  = mk(1, 1, 3'b111, 24'h000001, 0, 0, 0, 0, 24'hAA22CC, 24'hAA22CC);
    tbl[4]  = mk(1, 6, 3'b111, 24'h000006, 0, 0, 1, 6, 24'hAA22CC, 24'h000006);
    tbl[5]  = mk(0, 0, 3'b000, 24'h000000, 1, 1, 1, 6, 24'h000001, 24'h000006);
    tbl[6]  = mk(0, 0, 3'b000, 24'h000000, 1, 6, 1, 6, 24'h000006, 24'h000006);
    tbl[7]  = mk(0, 0, 3'b000, 24'h000000, 1, 1, 0, 0, 24'h000001, 24'h000006);
    tbl[8]  = mk(1, 3, 3'b111, 24'h0F0F0F, 0, 0, 0, 0, 24'h000001, 24'h000006);
    tbl[9]  = mk(1, 3, 3'b000, 24'hFFFFFF, 1, 3, 0, 0, 24'h0F0F0F, 24'h000006);
    tbl[10] = mk(0, 0, 3'b000, 24'h000000, 0, 0, 1, 3, 24'h0F0F0F, 24'h0F0F0F);
    tbl[11] = mk(1, 4, 3'b101, 24'h123456, 1, 4, 1, 4, 24'h120056, 24'h120056);
    tbl[12] = mk(1, 2, 3'b100, 24'hABCDEF, 1, 2, 1, 4, 24'hAB0000, 24'h120056);
    tbl[13] = mk(1, 7, 3'b001, 24'h0000FF, 1, 0, 1, 7, 24'h000000, 24'h0000FF);

    rst = 0;
    idle_in();
    #2 rst = 1;
    #1;
    chk("rst_busy", {23'd0, busy}, 24'd1);
    chk("rst_do0", dataout0, 24'h0);
    chk("rst_do1", dataout1, 24'h0);
    cyc();
    cyc();
    rst = 0;
    sweep_len("init");
    read_all_zero("init_rd");

    for (int i = 0; i < 14; i++) begin
      load = tbl[i].ld; windex = tbl[i].wi; wmask = tbl[i].wm;
      datain = tbl[i].din;
      read0 = tbl[i].rd0; rindex0 = tbl[i].ri0;
      read1 = tbl[i].rd1; rindex1 = tbl[i].ri1;
      cyc();
      chk($sformatf("vec%0d_do0", i), dataout0, tbl[i].e0);
      chk($sformatf("vec%0d_do1", i), dataout1, tbl[i].e1);
      chk($sformatf("vec%0d_busy", i), {23'd0, busy}, 24'd0);
    end
    idle_in();

    clear = 1; load = 1; windex = 2; wmask = 3'b111;
    datain = 24'h123456; read0 = 1; rindex0 = 2;
    cyc();
    chk("clr_busy", {23'd0, busy}, 24'd1);
    chk("clr_fwd", dataout0, 24'h123456);
    chk("clr_hold1", dataout1, 24'h0000FF);
    for (int i = 1; i <= 8; i++) begin
      clear = 1; load = 1; windex = 3'(i % 8); wmask = 3'b111;
      datain = 24'hFFFFFF;
      read0 = 1; rindex0 = 2; read1 = 1; rindex1 = 3'(i % 8);
      cyc();
      chk($sformatf("swp%0d_do0", i), dataout0, 24'h123456);
      chk($sformatf("swp%0d_do1", i), dataout1, 24'h0000FF);
      chk($sformatf("swp%0d_busy", i), {23'd0, busy},
          (i < 8) ? 24'd1 : 24'd0);
    end
    idle_in();
    read_all_zero("clr_rd");

    load = 1; windex = 5; wmask = 3'b111; datain = 24'h5A5A5A;
    cyc();
    idle_in();
    read0 = 1; rindex0 = 5; read1 = 1; rindex1 = 5;
    cyc();
    chk("pre_do0", dataout0, 24'h5A5A5A);
    chk("pre_do1", dataout1, 24'h5A5A5A);
    idle_in();
    clear = 1;
    cyc();
    clear = 0;
    chk("mid_busy", {23'd0, busy}, 24'd1);
    cyc();
    cyc();
    cyc();
    #2 rst = 1;
    #1;
    chk("mid_do0", dataout0, 24'h0);
    chk("mid_do1", dataout1, 24'h0);
    chk("mid_rbusy", {23'd0, busy}, 24'd1);
    cyc();
    rst = 0;
    sweep_len("mid");
    read0 = 1; rindex0 = 5; read1 = 1; rindex1 = 5;
    cyc();
    chk("post_do0", dataout0, 24'h0);
    chk("post_do1", dataout1, 24'h0);
    idle_in();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/dcache_array_swp.md
# dcache_array_swp

Parametrised successor to the cache register array, used for tag, valid, dirty and LRU storage in the data cache. It adds:
- two independent registered read ports;
- granule-masked writes, with same-cycle per-granule forwarding to both read ports;
- a self-timed clear sequencer that zeroes every set one per cycle, after reset and on request, so the array itself needs no reset fan-out.

The cache controller sits above it and must stall on `busy`.

## Interface
Parameters:
- `s_index`, 3: index width; `num_sets` = 2**`s_index`.
- `width`, 24: entry width in bits.
- `gran`, 8: write-mask granule in bits. `width` must be a multiple of `gran`; `nmask` = `width`/`gran`.

Ports:
- `clk`  in  1  single clock, all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `clear`  in  1  request a full sweep to zero.
- `busy`  out  1  sweep in progress; reads and writes are ignored.
- `read0`  in  1  port 0 read enable.
- `rindex0`  in  `s_index`  port 0 read index.
- `dataout0`  out  `width`  port 0 registered read data.
- `read1`  in  1  port 1 read enable.
- `rindex1`  in  `s_index`  port 1 read index.
- `dataout1`  out  `width`  port 1 registered read data.
- `load`  in  1  write enable.
- `windex`  in  `s_index`  write index.
- `wmask`  in  `nmask`  per-granule write enable; bit g covers bits [g*`gran` +: `gran`].
- `datain`  in  `width`  write data.

## Operation
State machine: IDLE, SWEEP; sweep pointer `ptr` is `s_index` bits.

Reset (async, `rst`=1):
- state=SWEEP, `ptr`=0, `dataout0`=`dataout1`=0, `busy`=1.
- Array contents are not reset; the sweep clears them.

SWEEP, each cycle:
- `data[ptr]` <= 0; `ptr` <= `ptr`+1.
- When `ptr`==`num_sets`-1: write set `num_sets`-1, then state <= IDLE and `ptr` <= 0.
- `load`, `read0`, `read1` and `clear` are ignored. Dataouts hold their value. `clear` does not restart the sweep.

IDLE:
- `clear`=1: state <= SWEEP next edge. A `load` and reads in that same cycle are still performed normally.
- `load`=1: for each g with `wmask`[g]=1, `data[windex]` granule g <= `datain` granule g. Other granules are unchanged. `wmask`=0 makes the write a no-op.
- `readN`=1: `dataoutN` <= the forwarded value.
  - Forwarded value: if `load` && `windex`==`rindexN`, granules with `wmask`[g]=1 come from `datain`, the rest from `data[rindexN]`.
  - Otherwise the value is `data[rindexN]`.
- `readN`=0: `dataoutN` holds.
- Both ports may read the same index in the same cycle; both get identical data.

`busy` = (state==SWEEP). It is decoded from registered state, with no combinational path from any input.

## Timing
- Read latency is 1 cycle: data for `rindexN` sampled at edge k appears on `dataoutN` after edge k.
- A write at edge k is visible:
  - through forwarding to a read at the same edge k;
  - through the array to reads at edge k+1 and later.
- Sweep length:
  - After `rst` deasserts, `busy` stays 1 for exactly `num_sets` rising edges.
  - `clear` sampled in IDLE at edge k raises `busy` after edge k. `busy` then stays high for `num_sets` cycles and falls after edge k+`num_sets`.
- First usable read or write edge is the first edge with `busy`=0.
- `rst` asserted mid-sweep or mid-write restarts the sweep at `ptr`=0 immediately. Dataouts go to 0 asynchronously.

## Test plan
- Reset sweep: `s_index`=3, drive `rst` then release. `busy`=1 for 8 edges, then 0. Read sets 0..7 on both ports: every result is 0x000000.
- Masked write and forwarding:
  - Write set 5 with `datain`=0xAABBCC, `wmask`=3'b111.
  - Next cycle, write set 5 with `datain`=0x112233, `wmask`=3'b010, with `read0`, `rindex0`=5 in the same cycle. `dataout0`=0xAA22CC one cycle later.
  - Read set 5 again: 0xAA22CC.
- Dual port:
  - Write set 1=0x000001 and set 6=0x000006.
  - Read `rindex0`=1 and `rindex1`=6 in one cycle: 0x000001 and 0x000006 respectively.
  - Then read both ports at 6: both 0x000006. Deassert `read1`: `dataout1` holds 0x000006.
- Clear with a simultaneous write:
  - With sets filled, assert `clear` and `load` (set 2, 0x123456, full mask) in the same cycle. `busy` is high for 8 cycles.
  - Reads and loads issued while `busy` is high change nothing.
  - After the sweep, every set reads 0.
- Reset mid-sweep: assert `rst` during sweep cycle 4. Dataouts go to 0 immediately; after release, `busy` is high for a full 8 cycles.
- `wmask`=0: issue a `load` with `wmask`=0 to a set holding 0x0F0F0F, with a same-cycle read of that set. The read returns 0x0F0F0F and the array is unchanged.
